// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle ADD/SUB/logic/compare ops and a W-step shift-add multiply,
// with a valid/ready handshake on the request and result sides.
module alu_mc #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [2:0]   op,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] result,
   output logic         carry,
   output logic         zero,
   output logic         overflow
);

   localparam int CW = $clog2(W + 1);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_e;
   typedef enum logic [2:0] {
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_SLTU, OP_MUL
   } op_e;

   state_e           state;
   logic [2*W-1:0]   mcand;
   logic [2*W-1:0]   acc;
   logic [2*W-1:0]   acc_nx;
   logic [W-1:0]     mplier;
   logic [CW-1:0]    cnt;

   logic             sub;
   logic [W-1:0]     bx;
   logic [W:0]       sum;
   logic [W-1:0]     alu_r;
   logic             alu_c;
   logic             alu_v;

   assign in_ready  = (state == S_IDLE) && !rst;
   assign out_valid = (state == S_DONE);

   always_comb begin
      sub   = (op_e'(op) == OP_SUB);
      bx    = b ^ {W{sub}};
      sum   = {1'b0, a} + {1'b0, bx} + {{W{1'b0}}, sub};
      alu_r = '0;
      alu_c = 1'b0;
      alu_v = 1'b0;
      case (op_e'(op))
         OP_ADD, OP_SUB: begin
            alu_r = sum[W-1:0];
            alu_c = sum[W];
            alu_v = (a[W-1] == bx[W-1]) && (sum[W-1] != a[W-1]);
         end
         OP_AND:  alu_r = a & b;
         OP_OR:   alu_r = a | b;
         OP_XOR:  alu_r = a ^ b;
         OP_SLT:  alu_r = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_SLTU: alu_r = {{(W-1){1'b0}}, (a < b)};
         default: ;
      endcase
   end

   // Product of this step; the final step registers it straight into result.
   assign acc_nx = acc + (mplier[0] ? mcand : '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         result   <= '0;
         carry    <= 1'b0;
         zero     <= 1'b0;
         overflow <= 1'b0;
         acc      <= '0;
         mcand    <= '0;
         mplier   <= '0;
         cnt      <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  if (op_e'(op) == OP_MUL) begin
                     mcand  <= {{W{1'b0}}, a};
                     mplier <= b;
                     acc    <= '0;
                     cnt    <= CW'(W);
                     state  <= S_MUL;
                  end else begin
                     result   <= alu_r;
                     carry    <= alu_c;
                     overflow <= alu_v;
                     zero     <= (alu_r == '0);
                     state    <= S_DONE;
                  end
               end
            end
            S_MUL: begin
               acc    <= acc_nx;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               if (cnt != '0) cnt <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  result   <= acc_nx[W-1:0];
                  carry    <= |acc_nx[2*W-1:W];
                  zero     <= (acc_nx[W-1:0] == '0);
                  overflow <= 1'b0;
                  state    <= S_DONE;
               end
            end
            S_DONE: begin
               if (out_ready) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc (W = 8): stimulus pushes model results, a negedge monitor pops them.
module tb_alu_mc;

   localparam int W = 8;

   typedef struct packed {
      logic [W-1:0] r;
      logic         c;
      logic         z;
      logic         v;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [2:0]   op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic         carry;
   logic         zero;
   logic         overflow;

   exp_t sb[$];
   exp_t mon_e;
   exp_t mon_got;
   int   checks = 0;
   int   errors = 0;
   bit   rnd_bp = 1'b0;
   int   n_add;
   int   n_mul;
   bit   saw_ready;

   alu_mc #(.W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .carry     (carry),
      .zero      (zero),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   // Reference model in plain integer arithmetic.
   function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      exp_t e;
      int ux, uy, sx, sy, t;
      ux = x;
      uy = y;
      sx = $signed(x);
      sy = $signed(y);
      e  = '0;
      case (o)
         3'd0: begin
            t = ux + uy;       e.r = W'(t); e.c = (t > 255);
            e.v = ((sx + sy) > 127) || ((sx + sy) < -128);
         end
         3'd1: begin
            t = ux - uy;       e.r = W'(t); e.c = (ux >= uy);
            e.v = ((sx - sy) > 127) || ((sx - sy) < -128);
         end
         3'd2: e.r = x & y;
         3'd3: e.r = x | y;
         3'd4: e.r = x ^ y;
         3'd5: e.r = (sx < sy) ? W'(1) : W'(0);
         3'd6: e.r = (ux < uy) ? W'(1) : W'(0);
         default: begin
            t = ux * uy;       e.r = W'(t); e.c = (t > 255);
         end
      endcase
      e.z = (e.r == '0);
      return e;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic send(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      int n;
      bit ok;
      n  = 0;
      ok = 1'b0;
      op = o;
      a  = x;
      b  = y;
      in_valid = 1'b1;
      while (n < 200 && !ok) begin
         @(negedge clk);
         if (in_ready) ok = 1'b1;
         else begin
            @(posedge clk);
            #1;
            if (rnd_bp) out_ready = 1'($urandom_range(0, 1));
            n++;
         end
      end
      if (!ok) check("accept_timeout", 32'(ok), 32'd1);
      else begin
         sb.push_back(model(o, x, y));
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(output int n, output bit sr);
      n  = 0;
      sr = 1'b0;
      do begin
         @(negedge clk);
         n++;
         if (in_ready && !out_valid) sr = 1'b1;
      end while (!out_valid && n < 100);
      if (!out_valid) check("valid_timeout", 32'(out_valid), 32'd1);
   endtask

   task automatic drain();
      int n;
      n = 0;
      out_ready = 1'b1;
      while ((sb.size() != 0 || out_valid) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) check("drain_timeout", 32'(sb.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string name);
      check({name, "_in_ready"}, 32'(in_ready), 32'd0);
      check({name, "_out_valid"}, 32'(out_valid), 32'd0);
      check({name, "_result"}, 32'(result), 32'd0);
      check({name, "_flags"}, {29'd0, carry, zero, overflow}, 32'd0);
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
            mon_got = {result, carry, zero, overflow};
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_result actual=%0h required=none", mon_got);
            end else begin
               mon_e = sb.pop_front();
               if (mon_got !== mon_e) begin
                  errors++;
                  $display("FAIL result_flags actual r=%0h c=%0b z=%0b v=%0b required r=%0h c=%0b z=%0b v=%0b",
                           mon_got.r, mon_got.c, mon_got.z, mon_got.v, mon_e.r, mon_e.c, mon_e.z, mon_e.v);
               end
            end
         end
      end
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("in_ready_after_reset", 32'(in_ready), 32'd1);

      send(3'd0, 8'h7F, 8'h01);
      wait_valid(n_add, saw_ready);
      check("add_latency", 32'(n_add), 32'd1);
      check("add_7f_result", 32'(result), 32'h80);
      check("add_7f_flags", {29'd0, carry, zero, overflow}, 32'b001);

      send(3'd1, 8'h05, 8'h05);
      send(3'd1, 8'h00, 8'h01);

      send(3'd7, 8'h10, 8'h11);
      wait_valid(n_mul, saw_ready);
      check("mul_latency_delta", 32'(n_mul - n_add), 32'd8);
      check("mul_in_ready_low", 32'(saw_ready), 32'd0);
      check("mul_result", 32'(result), 32'h10);
      check("mul_flags", {29'd0, carry, zero, overflow}, 32'b100);

      send(3'd5, 8'hFF, 8'h01);
      send(3'd6, 8'hFF, 8'h01);
      drain();

      // Backpressure: result must hold while a second request waits on in_valid.
      out_ready = 1'b0;
      send(3'd0, 8'h03, 8'h04);
      in_valid = 1'b1; op = 3'd0; a = 8'h09; b = 8'h09;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_out_valid", 32'(out_valid), 32'd1);
         check("bp_result", 32'(result), 32'h07);
         check("bp_in_ready", 32'(in_ready), 32'd0);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("post_hs_in_ready", 32'(in_ready), 32'd1);
      check("post_hs_out_valid", 32'(out_valid), 32'd0);
      sb.push_back(model(3'd0, 8'h09, 8'h09));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      drain();

      // Reset during the third multiply step.
      send(3'd7, 8'h23, 8'h45);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check_all_zero("abort");
      sb.delete();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("abort_out_valid", 32'(out_valid), 32'd0);
      check("abort_in_ready", 32'(in_ready), 32'd1);
      send(3'd0, 8'h01, 8'h01);
      wait_valid(n_add, saw_ready);
      check("fresh_add_result", 32'(result), 32'h02);
      drain();

      send(3'd0, 8'hFF, 8'h01);
      send(3'd1, 8'h80, 8'h01);
      send(3'd7, 8'hFF, 8'hFF);
      send(3'd0, 8'h80, 8'h80);
      send(3'd5, 8'h80, 8'h7F);
      send(3'd6, 8'h00, 8'h00);
      send(3'd7, 8'h00, 8'h5A);

      rnd_bp = 1'b1;
      for (int i = 0; i < 150; i++)
         send(3'($urandom_range(0, 7)), W'($urandom), W'($urandom));
      rnd_bp = 1'b0;
      drain();
      check("scoreboard_empty", 32'(sb.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
